// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequential ALU with single-cycle logic/arith ops and iterative
// multiply (shift-add) / divide (restoring), one bit per clock.
//
// Configuration:
//   ALU_SEQ_DIV_EN  when defined, opcode 1001 is an unsigned divide; when
//                   undefined the divider is not built and 1001 is illegal.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   request; accepted only while busy=0
//   a, b       in   operands (WIDTH), captured on accepted start
//   op         in   opcode (4), captured on accepted start
//   result     out  low result / quotient
//   result_hi  out  MUL high half / DIV remainder, 0 otherwise
//   zero       out  result == 0
//   carry_out  out  carry out of MSB (ADD/SUB only)
//   overflow   out  signed overflow (ADD/SUB), nonzero high half (MUL)
//   busy       out  iterative operation in progress
//   done       out  one-cycle pulse; outputs valid from this cycle
//   error      out  illegal opcode or divide by zero on last operation
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSlt = 4'b0111;
    localparam logic [3:0] OpNor = 4'b1100;
    localparam logic [3:0] OpMul = 4'b1000;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OpDiv = 4'b1001;
`endif

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    // Multiplicand for MUL, divisor for DIV.
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    // Working register: MUL {partial product hi, multiplier/product lo},
    // DIV {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   p_q, p_d, p_step;
`ifdef ALU_SEQ_DIV_EN
    logic                 run_div_q, run_div_d;
`endif

    logic [WIDTH-1:0]     res_d, hi_d;
    logic                 zero_d, carry_d, ovf_d, err_d, done_d;

    // ------------------------------------------------------------------
    // Single-cycle decode of the presented operation.
    // ------------------------------------------------------------------
    logic [WIDTH:0]       add_sum, sub_diff;
    logic                 slt_bit;
    logic [WIDTH-1:0]     sc_res, sc_hi;
    logic                 sc_carry, sc_ovf, sc_err, sc_run, sc_div;

    assign add_sum  = {1'b0, a} + {1'b0, b};
    assign sub_diff = {1'b0, a} - {1'b0, b};
    assign slt_bit  = $signed(a) < $signed(b);

    always_comb begin
        sc_res   = '0;
        sc_hi    = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_err   = 1'b0;
        sc_run   = 1'b0;
        sc_div   = 1'b0;
        case (op)
            OpAnd: sc_res = a & b;
            OpOr:  sc_res = a | b;
            OpNor: sc_res = ~(a | b);
            OpAdd: begin
                sc_res   = add_sum[WIDTH-1:0];
                sc_carry = add_sum[WIDTH];
                sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OpSub: begin
                sc_res   = sub_diff[WIDTH-1:0];
                // No borrow out means a >= b unsigned.
                sc_carry = ~sub_diff[WIDTH];
                sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OpSlt: sc_res = {{(WIDTH-1){1'b0}}, slt_bit};
            OpMul: sc_run = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            OpDiv: begin
                if (b == '0) begin
                    sc_res = '1;
                    sc_hi  = a;
                    sc_err = 1'b1;
                end else begin
                    sc_run = 1'b1;
                    sc_div = 1'b1;
                end
            end
`endif
            default: sc_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration of the shift-add multiplier / restoring divider.
    // ------------------------------------------------------------------
    logic [WIDTH:0]       mul_sum;

    assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : '0);

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]       div_shift, div_trial;
    logic                 div_fits;

    // Bring the next dividend bit into the partial remainder.
    assign div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opnd_q};
    assign div_fits  = div_shift >= {1'b0, opnd_q};

    always_comb begin
        if (run_div_q) begin
            // Remainder is always < divisor, so the kept value fits WIDTH bits.
            p_step = {(div_fits ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      p_q[WIDTH-2:0], div_fits};
        end else begin
            p_step = {mul_sum, p_q[WIDTH-1:1]};
        end
    end
`else
    assign p_step = {mul_sum, p_q[WIDTH-1:1]};
`endif

    // ------------------------------------------------------------------
    // Control: next state and registered outputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        p_d     = p_q;
`ifdef ALU_SEQ_DIV_EN
        run_div_d = run_div_q;
`endif
        res_d   = result;
        hi_d    = result_hi;
        zero_d  = zero;
        carry_d = carry_out;
        ovf_d   = overflow;
        err_d   = error;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (sc_run) begin
                        state_d = StRun;
                        cnt_d   = CntW'(WIDTH - 1);
                        opnd_d  = sc_div ? b : a;
                        p_d     = {{WIDTH{1'b0}}, (sc_div ? a : b)};
`ifdef ALU_SEQ_DIV_EN
                        run_div_d = sc_div;
`endif
                    end else begin
                        res_d   = sc_res;
                        hi_d    = sc_hi;
                        zero_d  = (sc_res == '0);
                        carry_d = sc_carry;
                        ovf_d   = sc_ovf;
                        err_d   = sc_err;
                        done_d  = 1'b1;
                    end
                end
            end
            StRun: begin
                p_d = p_step;
                if (cnt_q == '0) begin
                    // Last iteration: publish its result directly.
                    state_d = StIdle;
                    res_d   = p_step[WIDTH-1:0];
                    hi_d    = p_step[2*WIDTH-1:WIDTH];
                    zero_d  = (p_step[WIDTH-1:0] == '0);
                    carry_d = 1'b0;
`ifdef ALU_SEQ_DIV_EN
                    ovf_d   = !run_div_q && (p_step[2*WIDTH-1:WIDTH] != '0);
`else
                    ovf_d   = (p_step[2*WIDTH-1:WIDTH] != '0);
`endif
                    err_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            opnd_q    <= '0;
            p_q       <= '0;
`ifdef ALU_SEQ_DIV_EN
            run_div_q <= 1'b0;
`endif
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b1;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            error     <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            p_q       <= p_d;
`ifdef ALU_SEQ_DIV_EN
            run_div_q <= run_div_d;
`endif
            result    <= res_d;
            result_hi <= hi_d;
            zero      <= zero_d;
            carry_out <= carry_d;
            overflow  <= ovf_d;
            error     <= err_d;
            done      <= done_d;
        end
    end

    assign busy = (state_q == StRun);

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq (WIDTH=8).
// Flag vector order: {done, busy, error, zero, carry_out, overflow}.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic [3:0]   op;
    logic [W-1:0] result, result_hi;
    logic         zero, carry_out, overflow, busy, done, error;
    logic [5:0]   flg;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign flg = {done, busy, error, zero, carry_out, overflow};

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .op        (op),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    // Present one request for a single edge; returns in the cycle after acceptance.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for done, counting latency from acceptance and busy cycles seen.
    task automatic wait_done(output int lat, output int nb);
        lat = 1; nb = 0;
        while (!done && lat < 40) begin
            if (busy) nb++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (flg !== 6'b000100) begin
            tests_failed++; $display("FAIL reset_flags: got %b want %b", flg, 6'b000100);
        end
        tests_run++;
        if ({result_hi, result} !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_result: got %h want 0000", {result_hi, result});
        end
        rst = 1'b0;
    endtask

    task automatic test_add;
        issue(4'b0010, 8'h7F, 8'h01);
        tests_run++;
        if (flg !== 6'b100001 || result !== 8'h80 || result_hi !== 8'h00) begin
            tests_failed++;
            $display("FAIL add_7f_01: got flg=%b res=%h hi=%h want flg=100001 res=80 hi=00",
                     flg, result, result_hi);
        end
        // Done is a single pulse and results hold.
        @(posedge clk); #1;
        tests_run++;
        if (flg !== 6'b000001 || result !== 8'h80) begin
            tests_failed++;
            $display("FAIL add_hold: got flg=%b res=%h want flg=000001 res=80", flg, result);
        end
        issue(4'b0010, 8'hFF, 8'h01);
        tests_run++;
        if (flg !== 6'b100110 || result !== 8'h00) begin
            tests_failed++;
            $display("FAIL add_ff_01: got flg=%b res=%h want flg=100110 res=00", flg, result);
        end
    endtask

    task automatic test_sub_slt;
        issue(4'b0110, 8'h05, 8'h05);
        tests_run++;
        if (flg !== 6'b100110 || result !== 8'h00) begin
            tests_failed++;
            $display("FAIL sub_5_5: got flg=%b res=%h want flg=100110 res=00", flg, result);
        end
        issue(4'b0110, 8'h03, 8'h05);
        tests_run++;
        if (flg !== 6'b100000 || result !== 8'hFE) begin
            tests_failed++;
            $display("FAIL sub_3_5: got flg=%b res=%h want flg=100000 res=fe", flg, result);
        end
        issue(4'b0110, 8'h80, 8'h01);
        tests_run++;
        if (flg !== 6'b100011 || result !== 8'h7F) begin
            tests_failed++;
            $display("FAIL sub_80_1: got flg=%b res=%h want flg=100011 res=7f", flg, result);
        end
        issue(4'b0111, 8'hFF, 8'h01);
        tests_run++;
        if (flg !== 6'b100000 || result !== 8'h01) begin
            tests_failed++;
            $display("FAIL slt_ff_01: got flg=%b res=%h want flg=100000 res=01", flg, result);
        end
        issue(4'b0111, 8'h01, 8'hFF);
        tests_run++;
        if (flg !== 6'b100100 || result !== 8'h00) begin
            tests_failed++;
            $display("FAIL slt_01_ff: got flg=%b res=%h want flg=100100 res=00", flg, result);
        end
    endtask

    task automatic test_logic;
        logic [3:0] ops [3];
        logic [7:0] exp [3];
        ops = '{4'b0000, 4'b0001, 4'b1100};
        exp = '{8'h30, 8'hFC, 8'h03};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], 8'hF0, 8'h3C);
            tests_run++;
            if (flg !== 6'b100000 || result !== exp[i] || result_hi !== 8'h00) begin
                tests_failed++;
                $display("FAIL logic_op%b: got flg=%b res=%h hi=%h want flg=100000 res=%h hi=00",
                         ops[i], flg, result, result_hi, exp[i]);
            end
        end
    endtask

    task automatic test_mul;
        int lat, nb;
        issue(4'b1000, 8'hFF, 8'hFF);
        // Requests while busy must be ignored.
        op = 4'b0010; a = 8'h01; b = 8'h01; start = 1'b1;
        repeat (3) @(posedge clk);
        #1; start = 1'b0;
        wait_done(lat, nb);
        lat += 3; nb += 3;
        tests_run++;
        if (lat !== 9 || nb !== 8) begin
            tests_failed++; $display("FAIL mul_timing: got lat=%0d busy=%0d want lat=9 busy=8", lat, nb);
        end
        tests_run++;
        if (flg !== 6'b100001 || result !== 8'h01 || result_hi !== 8'hFE) begin
            tests_failed++;
            $display("FAIL mul_ff_ff: got flg=%b hi=%h res=%h want flg=100001 hi=fe res=01",
                     flg, result_hi, result);
        end
        issue(4'b1000, 8'h03, 8'h05);
        wait_done(lat, nb);
        tests_run++;
        if (lat !== 9 || flg !== 6'b100000 || result !== 8'h0F || result_hi !== 8'h00) begin
            tests_failed++;
            $display("FAIL mul_3_5: got lat=%0d flg=%b hi=%h res=%h want lat=9 flg=100000 hi=00 res=0f",
                     lat, flg, result_hi, result);
        end
    endtask

    task automatic test_div;
        int lat, nb;
`ifdef ALU_SEQ_DIV_EN
        issue(4'b1001, 8'd200, 8'd7);
        wait_done(lat, nb);
        tests_run++;
        if (lat !== 9 || nb !== 8 || flg !== 6'b100000 || result !== 8'd28 || result_hi !== 8'd4) begin
            tests_failed++;
            $display("FAIL div_200_7: got lat=%0d busy=%0d flg=%b q=%0d r=%0d want 9 8 100000 28 4",
                     lat, nb, flg, result, result_hi);
        end
        issue(4'b1001, 8'h2A, 8'h00);
        tests_run++;
        if (flg !== 6'b101000 || result !== 8'hFF || result_hi !== 8'h2A) begin
            tests_failed++;
            $display("FAIL div_by_zero: got flg=%b res=%h hi=%h want flg=101000 res=ff hi=2a",
                     flg, result, result_hi);
        end
`else
        issue(4'b1001, 8'd200, 8'd7);
        lat = 1; nb = 0;
        tests_run++;
        if (flg !== 6'b101100 || result !== 8'h00 || result_hi !== 8'h00) begin
            tests_failed++;
            $display("FAIL div_disabled: got flg=%b res=%h hi=%h want flg=101100 res=00 hi=00",
                     flg, result, result_hi);
        end
`endif
    endtask

    task automatic test_illegal;
        issue(4'b0011, 8'h12, 8'h34);
        tests_run++;
        if (flg !== 6'b101100 || result !== 8'h00 || result_hi !== 8'h00) begin
            tests_failed++;
            $display("FAIL illegal_op: got flg=%b res=%h hi=%h want flg=101100 res=00 hi=00",
                     flg, result, result_hi);
        end
        issue(4'b0010, 8'h01, 8'h02);
        tests_run++;
        if (flg !== 6'b100000 || result !== 8'h03) begin
            tests_failed++;
            $display("FAIL error_clear: got flg=%b res=%h want flg=100000 res=03", flg, result);
        end
    endtask

    task automatic test_reset_abort;
        int dones;
        issue(4'b1000, 8'hFF, 8'hFF);
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        #1;
        tests_run++;
        if (flg !== 6'b000100 || {result_hi, result} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL abort_reset: got flg=%b out=%h want flg=000100 out=0000",
                     flg, {result_hi, result});
        end
        @(posedge clk); #1; rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        tests_run++;
        if (dones !== 0) begin
            tests_failed++; $display("FAIL abort_no_done: got %0d active cycles want 0", dones);
        end
        issue(4'b0010, 8'h03, 8'h04);
        tests_run++;
        if (flg !== 6'b100000 || result !== 8'h07) begin
            tests_failed++;
            $display("FAIL abort_then_add: got flg=%b res=%h want flg=100000 res=07", flg, result);
        end
    endtask

    task automatic test_back_to_back;
        int lat, nb;
        issue(4'b1000, 8'h03, 8'h05);
        wait_done(lat, nb);
        tests_run++;
        if (lat !== 9 || result !== 8'h0F) begin
            tests_failed++; $display("FAIL b2b_mul: got lat=%0d res=%h want lat=9 res=0f", lat, result);
        end
        // Issue during the done cycle.
        issue(4'b0010, 8'd10, 8'd20);
        tests_run++;
        if (flg !== 6'b100000 || result !== 8'd30 || result_hi !== 8'h00) begin
            tests_failed++;
            $display("FAIL b2b_add: got flg=%b res=%0d hi=%h want flg=100000 res=30 hi=00",
                     flg, result, result_hi);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_add;
        test_sub_slt;
        test_logic;
        test_mul;
        test_div;
        test_illegal;
        test_reset_abort;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request; sampled only when Busy=0.
REQ-005 A  input  WIDTH  operand A, captured on accepted Start.
REQ-006 B  input  WIDTH  operand B, captured on accepted Start.
REQ-007 Operation  input  4  opcode, captured on accepted Start.
REQ-008 Result  output  WIDTH  low result / quotient.
REQ-009 Result_hi  output  WIDTH  MUL high half / DIV remainder; 0 for other ops.
REQ-010 Zero, Carry_out, Overflow  output  1 each  status flags.
REQ-011 Busy  output  1  operation in progress.
REQ-012 Done  output  1  one-cycle pulse; outputs valid from this cycle.
REQ-013 Error  output  1  illegal opcode or divide-by-zero for the last operation.

Function
REQ-014 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR, 1000 MUL (unsigned), 1001 DIV (unsigned); all others illegal.
REQ-015 Start accepted when Start=1 and Busy=0; Start while Busy=1 SHALL be ignored with no effect.
REQ-016 States SHALL be IDLE and RUN; IDLE->RUN on accepted MUL/DIV (with B!=0 for DIV); RUN->IDLE after exactly WIDTH iteration cycles.
REQ-017 Single-cycle ops, illegal opcodes, DIV by zero: outputs and Done=1 registered in the cycle after acceptance (latency 1); Busy stays 0.
REQ-018 MUL: shift-add, one bit per cycle; Busy=1 for WIDTH cycles after acceptance; Done pulses in the cycle Busy falls (latency WIDTH+1).
REQ-019 DIV: restoring, one quotient bit per cycle, same timing as MUL.
REQ-020 ADD/SUB SHALL be modulo 2^WIDTH; Carry_out = carry out of MSB (SUB: 1 when A>=B unsigned); Overflow = signed overflow.
REQ-021 MUL: {Result_hi,Result} = A*B full 2*WIDTH product; Overflow = (Result_hi!=0); Carry_out=0.
REQ-022 SLT: Result = 1 if A<B signed, else 0; Carry_out=Overflow=0.
REQ-023 Logic ops and DIV: Carry_out=Overflow=0.
REQ-024 Zero SHALL be 1 iff Result==0 (Result_hi ignored), evaluated for every op.
REQ-025 DIV with B=0: Result all ones, Result_hi=A, Error=1.
REQ-026 Illegal opcode: Result=0, Result_hi=0, Zero=1, other flags 0, Error=1.
REQ-027 Error SHALL be 0 for every legal, non-faulting operation.
REQ-028 Result, Result_hi, flags, Error SHALL hold their value until the next Done; intermediate iteration values SHALL NOT appear on them.
REQ-029 A new Start SHALL be accepted in the same cycle Done is high (Busy=0), giving back-to-back operation.

Reset
REQ-030 Reset=1 SHALL immediately force state IDLE, Busy=0, Done=0, Error=0, Result=0, Result_hi=0, Carry_out=0, Overflow=0, Zero=1.
REQ-031 Reset asserted during RUN SHALL abort the operation with no Done pulse.
REQ-032 First Start accepted on the first rising edge after Reset deasserts.

Configuration
REQ-033 Macro ALU_SEQ_DIV_EN: defined -> DIV per REQ-019/REQ-025; undefined -> divider logic absent and opcode 1001 treated as illegal per REQ-026.

Verification
REQ-034 WIDTH=8: ADD A=0x7F B=0x01 -> next cycle Done=1, Result=0x80, Overflow=1, Carry_out=0, Zero=0.
REQ-035 SUB A=0x05 B=0x05 -> Result=0x00, Zero=1, Carry_out=1, Overflow=0; SLT A=0xFF B=0x01 -> Result=0x01.
REQ-036 MUL A=0xFF B=0xFF -> Busy=1 for 8 cycles, Done at cycle 9, Result_hi=0xFE, Result=0x01, Overflow=1; Start during Busy ignored.
REQ-037 DIV A=200 B=7 -> Done at cycle 9, Result=28, Result_hi=4, Error=0; DIV B=0 -> Done cycle 1, Result=0xFF, Result_hi=A, Error=1; without ALU_SEQ_DIV_EN -> Result=0, Error=1.
REQ-038 Reset pulsed at cycle 4 of MUL -> all outputs at REQ-030 values, no Done; subsequent ADD 3+4 -> Result=7.
